alu_logic_dispatch: RTL and testbench
=====================================

Name: alu_logic_dispatch

Overview:
- Issue/collect stage wrapped around the registered 16-bit logic units (AND, OR, XOR, NOT).
- Accepts operation requests from the decode stage over a valid/ready handshake and registers the operands onto the units' shared input bus.
- Tracks the units' one-cycle result latency, selects the addressed unit's output and computes flags.
- Buffers tagged results in a small FIFO toward writeback, exerting credit-based backpressure.

Parameters:
- WIDTH, 16, datapath width; must match the logic units.
- TAG_W, 3, destination-register tag width.
- DEPTH, 4, result FIFO entries and total credit limit; legal range 3..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low; also drives the logic units' rst
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at posedge
- in_op  in  2  operation code (encodings under Decomposition)
- in_a  in  WIDTH  operand 1
- in_b  in  WIDTH  operand 2 (ignored for NOT)
- in_tag  in  TAG_W  destination tag
- lu_inp1  out  WIDTH  registered operand 1 to all logic units
- lu_inp2  out  WIDTH  registered operand 2 to all logic units
- lu_and_out  in  WIDTH  AND unit registered result
- lu_or_out  in  WIDTH  OR unit registered result
- lu_xor_out  in  WIDTH  XOR unit registered result
- lu_not_out  in  WIDTH  NOT unit registered result (~inp1)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts on out_valid & out_ready at posedge
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag of the result
- out_zero  out  1  result == 0
- out_neg  out  1  result[WIDTH-1]

Behaviour:
- Reset (rst low, async): lu_inp1/2 = 0, out_valid = 0, out_result = 0, out_tag = 0, out_zero = 0, out_neg = 0, in_ready = 0 while rst is low. Pipeline valid bits cleared; FIFO emptied. In-flight and buffered requests are discarded, not completed.
- Pipeline stages:
  - S1 (dispatch register): on accept at edge k, capture in_a/in_b into lu_inp1/lu_inp2 and capture op, tag and valid=1. If no accept, S1 valid=0 and lu_inp1/2 hold their last value.
  - S2 (unit register): at edge k+1 the units latch their results. The block shifts op, tag and valid from S1 to S2.
  - Collect: at edge k+2, if S2 valid, mux the lu_*_out selected by the S2 op, compute zero/neg, and push {result, tag, zero, neg} into the FIFO.
  - out_valid rises after edge k+2. Accept-to-out_valid latency is exactly 2 cycles when the FIFO is empty.
- Credits:
  - inflight = S1.valid + S2.valid.
  - in_ready = (fifo_count + inflight) < DEPTH, registered-free combinational, excluding same-cycle pops (conservative).
  - A push is therefore never lost; FIFO overflow is impossible by construction. An assertion checks push when full.
- Throughput: 1 op/cycle sustained when out_ready is held high (steady occupancy is 3, which is below DEPTH).
- FIFO:
  - First-word-fall-through: out_* reflect the head entry whenever out_valid=1.
  - Simultaneous push and pop in the same cycle is legal, and the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - out_* hold their value while out_valid & ~out_ready.
  - When empty, out_result/out_tag/flags are don't-care but are driven with the last value, never X.
- Order: results leave in strict acceptance order; there is no reordering.
- in_op values are all legal; there is no error path.
- Flags are computed from the selected WIDTH-bit result only.

Decomposition:
- Package alu_logic_pkg:
  - Op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11.
  - Result-entry struct {result, tag, zero, neg}.
  - Default WIDTH/TAG_W constants.
- Sub-module alu_result_fifo: parameterised FWFT sync FIFO with async active-low reset, exposing count, full and empty.
- Dispatch/tracking logic and the result mux stay in the top module.

Test Plan:
- AND issue: in_a=0x000B, in_b=0x000D, tag=1, out_ready=1 → 2 cycles after accept: out_result=0x0009, tag=1, zero=0, neg=0.
- XOR zero flag: 0xFFFF ^ 0xFFFF, tag=2 → out_result=0x0000, zero=1, neg=0. Then NOT 0x00FF → 0xFF00, neg=1.
- Back-to-back throughput: 8 consecutive ops (AND/OR/XOR/NOT mix, tags 0..7), out_ready=1 → in_ready stays 1, one result per cycle, tags 0..7 in order, values match the model.
- Backpressure: out_ready=0, in_valid held for 6 cycles → exactly 4 accepted, in_ready=0 thereafter. Raise out_ready → results with tags 0..3 drain in order, in_ready returns to 1, no loss or duplication.
- Reset mid-operation: accept 2 ops, assert rst between edges k+1 and k+2 → out_valid=0 immediately. After release, no stale results appear and the next op completes normally with 2-cycle latency.
- Simultaneous push/pop at full credit: FIFO holding 3 entries, out_ready toggling every cycle, in_valid=1 → count never exceeds DEPTH and output order matches the reference model.

Source files
------------

// File: rtl/alu_logic_dispatch_pkg.sv
// alu_logic_pkg: op encodings, result-entry layout and default widths for the logic dispatch stage
package alu_logic_pkg;
    localparam int ALU_WIDTH = 16;
    localparam int ALU_TAG_W = 3;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_TAG_W-1:0] tag;
        logic                 zero;
        logic                 neg;
    } res_entry_t;
endpackage

// File: rtl/alu_logic_dispatch_result_fifo.sv
// alu_result_fifo: first-word-fall-through result buffer; pointers wrap modulo DEPTH so any depth works
module alu_result_fifo
    import alu_logic_pkg::*;
#(
    parameter type T = res_entry_t,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty  = (cnt_q == '0);
        full   = (cnt_q == CW'(DEPTH));
        pop_ok = pop & ~empty;
        mem_d  = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d   = push ? nxt(wr_q) : wr_q;
        rd_d   = pop_ok ? nxt(rd_q) : rd_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop_ok);
        head   = mem_q[rd_q];
        count  = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Upstream credits make this unreachable; it guards against credit-logic regressions.
    assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule

// File: rtl/alu_logic_dispatch.sv
// alu_logic_dispatch: issues ops onto the shared logic-unit bus, collects results and buffers them for writeback
module alu_logic_dispatch
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int TAG_W = ALU_TAG_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] lu_inp1,
    output logic [WIDTH-1:0] lu_inp2,
    input  logic [WIDTH-1:0] lu_and_out,
    input  logic [WIDTH-1:0] lu_or_out,
    input  logic [WIDTH-1:0] lu_xor_out,
    input  logic [WIDTH-1:0] lu_not_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
    } entry_t;

    logic [WIDTH-1:0] inp1_q, inp1_d, inp2_q, inp2_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    alu_op_e          s1_op_q, s1_op_d, s2_op_q, s2_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic             accept;
    logic [WIDTH-1:0] sel;
    entry_t           push_data, head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;

    always_comb begin
        // Credits count every request that will eventually occupy a FIFO slot; same-cycle pops are ignored.
        in_ready   = rst & ~fifo_full &
                     ((int'(fifo_count) + int'(s1_valid_q) + int'(s2_valid_q)) < DEPTH);
        accept     = in_valid & in_ready;
        inp1_d     = accept ? in_a : inp1_q;
        inp2_d     = accept ? in_b : inp2_q;
        s1_valid_d = accept;
        s1_op_d    = accept ? alu_op_e'(in_op) : s1_op_q;
        s1_tag_d   = accept ? in_tag : s1_tag_q;
        s2_valid_d = s1_valid_q;
        s2_op_d    = s1_op_q;
        s2_tag_d   = s1_tag_q;
        sel        = (s2_op_q == OP_AND) ? lu_and_out :
                     (s2_op_q == OP_OR)  ? lu_or_out  :
                     (s2_op_q == OP_XOR) ? lu_xor_out : lu_not_out;
        push_data  = '{result: sel, tag: s2_tag_q, zero: ~|sel, neg: sel[WIDTH-1]};
        lu_inp1    = inp1_q;
        lu_inp2    = inp2_q;
        out_valid  = ~fifo_empty;
        out_result = head.result;
        out_tag    = head.tag;
        out_zero   = head.zero;
        out_neg    = head.neg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inp1_q     <= '0;
            inp2_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_AND;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= OP_AND;
            s2_tag_q   <= '0;
        end else begin
            inp1_q     <= inp1_d;
            inp2_q     <= inp2_d;
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q    <= s2_op_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    alu_result_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s2_valid_q),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_alu_logic_dispatch.sv
// tb_alu_logic_dispatch: randomized scenarios checked against a queue-based model of the dispatch stage
module tb_alu_logic_dispatch;
    localparam int W = 16;
    localparam int TW = 3;
    localparam int D = 4;

    logic          clk = 0, rst = 0;
    logic          in_valid = 0, in_ready, out_valid, out_ready = 0, out_zero, out_neg;
    logic [1:0]    in_op = 0;
    logic [W-1:0]  in_a = 0, in_b = 0, lu_inp1, lu_inp2, out_result;
    logic [W-1:0]  lu_and_out = 0, lu_or_out = 0, lu_xor_out = 0, lu_not_out = 0;
    logic [TW-1:0] in_tag = 0, out_tag;

    typedef struct {
        logic [W-1:0]  r;
        logic [TW-1:0] t;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            checks = 0, errors = 0, pre;
    logic          acc, pop, rdy, ov, o_z, o_n;
    logic [W-1:0]  o_res;
    logic [TW-1:0] o_tag;

    alu_logic_dispatch #(.WIDTH(W), .TAG_W(TW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .lu_inp1(lu_inp1), .lu_inp2(lu_inp2),
        .lu_and_out(lu_and_out), .lu_or_out(lu_or_out), .lu_xor_out(lu_xor_out),
        .lu_not_out(lu_not_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero), .out_neg(out_neg)
    );

    always #5 clk = ~clk;

    // Registered logic units sitting on the shared operand bus.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_and_out <= '0; lu_or_out <= '0; lu_xor_out <= '0; lu_not_out <= '0;
        end else begin
            lu_and_out <= lu_inp1 & lu_inp2;
            lu_or_out  <= lu_inp1 | lu_inp2;
            lu_xor_out <= lu_inp1 ^ lu_inp2;
            lu_not_out <= ~lu_inp1;
        end
    end

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // One cycle: drive, sample handshakes just before the edge, record accepted requests in the model.
    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic ordy);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
        #1;
        acc = in_valid && in_ready; pop = out_valid && out_ready; rdy = in_ready; ov = out_valid;
        o_res = out_result; o_tag = out_tag; o_z = out_zero; o_n = out_neg; pre = exp_q.size();
        if (acc) exp_q.push_back('{r: ref_op(op, a, b), t: tag});
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, out_zero, out_neg, out_tag, out_result, lu_inp1, lu_inp2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v%b r%b z%b n%b tag%0d res%h i1 %h i2 %h exp all zero",
                     out_valid, in_ready, out_zero, out_neg, out_tag, out_result, lu_inp1, lu_inp2);
        end
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready %b valid %b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_and;
        int lat = 0;
        drive(1, 2'd0, 16'h000B, 16'h000D, 3'd1, 1);
        checks++;
        if (!acc) begin errors++; $display("FAIL and_accept got %b exp 1", acc); end
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (pop) begin lat = i; void'(exp_q.pop_front()); end
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL and_latency got sample %0d exp 3", lat); end
        checks++;
        if ({o_res, o_tag, o_z, o_n} !== {16'h0009, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL and_result got %h/%0d z%b n%b exp 0009/1 z0 n0", o_res, o_tag, o_z, o_n);
        end
    endtask

    task automatic test_xor_not;
        logic [W+TW+1:0] got[2];
        int n = 0;
        drive(1, 2'd2, 16'hFFFF, 16'hFFFF, 3'd2, 1);
        drive(1, 2'd3, 16'h00FF, 16'h1234, 3'd3, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (pop && n < 2) begin got[n] = {o_res, o_tag, o_z, o_n}; n++; void'(exp_q.pop_front()); end
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL xor_not_count got %0d exp 2", n); end
        checks++;
        if (got[0] !== {16'h0000, 3'd2, 1'b1, 1'b0}) begin
            errors++; $display("FAIL xor_zero got %h exp %h", got[0], {16'h0000, 3'd2, 1'b1, 1'b0});
        end
        checks++;
        if (got[1] !== {16'hFF00, 3'd3, 1'b0, 1'b1}) begin
            errors++; $display("FAIL not_neg got %h exp %h", got[1], {16'hFF00, 3'd3, 1'b0, 1'b1});
        end
    endtask

    task automatic test_back_to_back;
        int first = -1, last = -1, npop = 0, nrdy = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 8) drive(1, 2'(c % 4), 16'($urandom), 16'($urandom), 3'(c), 1);
            else drive(0, 0, 0, 0, 0, 1);
            if (c < 8 && rdy) nrdy++;
            if (pop) begin
                if (first < 0) first = c;
                last = c;
                npop++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_spurious got tag %0d exp none", o_tag); end
                else begin
                    e = exp_q.pop_front();
                    if ({o_res, o_tag, o_z, o_n} !== {e.r, e.t, e.r == '0, e.r[W-1]}) begin
                        errors++;
                        $display("FAIL b2b_data got %h/%0d z%b n%b exp %h/%0d", o_res, o_tag, o_z, o_n, e.r, e.t);
                    end
                end
            end
        end
        checks++;
        if (nrdy != 8) begin errors++; $display("FAIL b2b_ready got %0d ready cycles exp 8", nrdy); end
        checks++;
        if (npop != 8 || last - first != 7) begin
            errors++; $display("FAIL b2b_rate got %0d pops over %0d cycles exp 8 over 8", npop, last - first + 1);
        end
    endtask

    task automatic test_backpressure;
        int nacc = 0, npop = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 3'(nacc), 0);
            checks++;
            if (rdy !== (pre < D)) begin errors++; $display("FAIL bp_credit got %b exp %b", rdy, pre < D); end
            if (acc) nacc++;
        end
        checks++;
        if (nacc != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", nacc); end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (rdy !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL bp_stall got ready %b valid %b exp 0 1", rdy, ov); end
        checks++;
        if (exp_q.size() == 0 || o_res !== exp_q[0].r || o_tag !== exp_q[0].t) begin
            errors++; $display("FAIL bp_head got %h/%0d exp model head", o_res, o_tag);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_dup got tag %0d exp none", o_tag); end
                else begin
                    e = exp_q.pop_front();
                    if (o_res !== e.r || o_tag !== e.t || o_tag !== 3'(npop)) begin
                        errors++; $display("FAIL bp_drain got %h/%0d exp %h/%0d", o_res, o_tag, e.r, e.t);
                    end
                end
                npop++;
            end
        end
        checks++;
        if (npop != 4 || rdy !== 1'b1) begin errors++; $display("FAIL bp_final got %0d pops ready %b exp 4 1", npop, rdy); end
    endtask

    task automatic test_reset_mid;
        int lat = 0, stale = 0;
        drive(1, 2'd1, 16'h1111, 16'h2222, 3'd5, 1);
        drive(1, 2'd2, 16'h3333, 16'h4444, 3'd6, 1);
        rst = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid got valid %b ready %b exp 0 0", out_valid, in_ready);
        end
        exp_q.delete();
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        repeat (5) begin drive(0, 0, 0, 0, 0, 1); if (ov) stale++; end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rst_stale got %0d valid cycles exp 0", stale); end
        drive(1, 2'd3, 16'h8001, 16'h0000, 3'd4, 1);
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (pop) lat = i;
        end
        checks++;
        if (lat != 3 || exp_q.size() != 1 || o_res !== exp_q[0].r || o_tag !== 3'd4) begin
            errors++; $display("FAIL rst_recover got sample %0d res %h tag %0d exp 3 7ffe 4", lat, o_res, o_tag);
        end
        exp_q.delete();
    endtask

    task automatic test_simul;
        int tag = 0;
        repeat (3) begin drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 3'(tag), 0); tag++; end
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 60; c++) begin
            if (c < 40) drive(1, 2'($urandom), 16'($urandom), 16'($urandom), 3'(tag), c[0]);
            else drive(0, 0, 0, 0, 0, 1);
            if (acc) tag++;
            checks++;
            if (rdy !== (pre < D) || exp_q.size() > D) begin
                errors++; $display("FAIL simul_credit got ready %b outstanding %0d exp %b <=%0d", rdy, exp_q.size(), pre < D, D);
            end
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL simul_spurious got tag %0d exp none", o_tag); end
                else begin
                    e = exp_q.pop_front();
                    if ({o_res, o_tag, o_z, o_n} !== {e.r, e.t, e.r == '0, e.r[W-1]}) begin
                        errors++;
                        $display("FAIL simul_data got %h/%0d z%b n%b exp %h/%0d", o_res, o_tag, o_z, o_n, e.r, e.t);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL simul_drain got %0d left exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_and;
        test_xor_not;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_simul;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
